dmem_port_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).
//  - Arbitrates, latches the winning request and sequences one memory access.
//  - Returns read data with an ack pulse.
//  - Rejects misaligned or out-of-range addresses without touching memory.
//  - Sits between the pipeline MEM stage / loader and the data memory.

---
 rtl/dmem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory: IDLE -> ACCESS -> RESP per access.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-breaking; without it port 0 always wins ties.
module dmem_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_WriteData,
    input  logic [DATA_W-1:0] mem_ReadData
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // One extra bit so the limit 4*MEM_WORDS is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * MEM_WORDS);

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        addr_err = (a[1:0] != 2'b00) || ({1'b0, a} >= ADDR_LIMIT);
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic                grant_s;
    logic                tie_grant_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                we_r;
    logic                err_r;
    logic                port_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata_r;

`ifdef DMEM_ARB_RR_EN
    logic                rr_last_r;

    // Remember the most recent winner so a tie goes to the other port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && (p0_req || p1_req)) begin
            rr_last_r <= grant_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    assign tie_grant_s = ~rr_last_r;
`else
    assign tie_grant_s = 1'b0;
`endif

    // Next-state and winner selection.
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (p0_req && p1_req) begin
                    grant_s    = tie_grant_s;
                    state_nx_s = ST_ACCESS;
                end else if (p0_req || p1_req) begin
                    grant_s    = p1_req;
                    state_nx_s = ST_ACCESS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nx_s = ST_RESP;
            ST_RESP:   state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    assign sel_we_s    = grant_s ? p1_we    : p0_we;
    assign sel_addr_s  = grant_s ? p1_addr  : p0_addr;
    assign sel_wdata_s = grant_s ? p1_wdata : p0_wdata;

    // State register, request latch and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            port_r  <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        we_r    <= sel_we_s;
                        err_r   <= addr_err(sel_addr_s);
                        port_r  <= grant_s;
                        addr_r  <= sel_addr_s;
                        wdata_r <= sel_wdata_s;
                    end else begin
                        we_r    <= we_r;
                    end
                end
                ST_ACCESS: begin
                    rdata_r <= (we_r || err_r) ? {DATA_W{1'b0}} : mem_ReadData;
                end
                default: begin
                    rdata_r <= rdata_r;
                end
            endcase
        end
    end

    // Output decode; a store is squashed by reset arriving in its ACCESS cycle.
    always_comb begin
        mem_MemRead   = 1'b0;
        mem_MemWrite  = 1'b0;
        mem_Address   = {ADDR_W{1'b0}};
        mem_WriteData = {DATA_W{1'b0}};
        p0_ack        = 1'b0;
        p0_err        = 1'b0;
        p0_rdata      = {DATA_W{1'b0}};
        p1_ack        = 1'b0;
        p1_err        = 1'b0;
        p1_rdata      = {DATA_W{1'b0}};
        case (state_r)
            ST_ACCESS: begin
                mem_MemRead   = ~we_r & ~err_r;
                mem_MemWrite  = we_r & ~err_r & ~reset;
                mem_Address   = addr_r;
                mem_WriteData = wdata_r;
            end
            ST_RESP: begin
                if (port_r) begin
                    p1_ack   = 1'b1;
                    p1_err   = err_r;
                    p1_rdata = rdata_r;
                end else begin
                    p0_ack   = 1'b1;
                    p0_err   = err_r;
                    p0_rdata = rdata_r;
                end
            end
            default: begin
                mem_MemRead = 1'b0;
            end
        endcase
    end

endmodule
